// File: rtl/seg_scan_if.sv
// seg_scan_if: load handshake and display-drive signals of the seven-segment scan controller.
interface seg_scan_if #(parameter int NUM_DIGITS = 4);
  logic                    load_valid;
  logic                    load_ready;
  logic [4*NUM_DIGITS-1:0] load_data;
  logic [NUM_DIGITS-1:0]   load_dp;
  logic [3:0]              bcd_out;
  logic [NUM_DIGITS-1:0]   an;
  logic                    dp_out;
  logic                    frame_tick;
  modport master (output load_valid, load_data, load_dp,
                  input  load_ready, bcd_out, an, dp_out, frame_tick);
  modport slave  (input  load_valid, load_data, load_dp,
                  output load_ready, bcd_out, an, dp_out, frame_tick);
endinterface

// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: time-multiplexed common-anode 7-seg scanner with frame-aligned word loading.
// Optional LEADING_ZERO_BLANK_EN blanks leading zero digits (digit 0 always shown).
module seg_scan_ctrl #(
  parameter int NUM_DIGITS = 4,
  parameter int CLK_DIV    = 50000,
  parameter int BLANK_CYC  = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  seg_scan_if.slave   bus
);
  localparam int CW = $clog2(CLK_DIV);
  localparam int IW = $clog2(NUM_DIGITS);
  localparam logic [CW-1:0] LAST_C = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] BLK_C  = CW'(BLANK_CYC);
  localparam logic [IW-1:0] LAST_I = IW'(NUM_DIGITS - 1);
  typedef enum logic {BLANK, ON} phase_e;
  phase_e                           phase_q, phase_d;
  logic [CW-1:0]                    cnt_q, cnt_d;
  logic [IW-1:0]                    idx_q, idx_d;
  logic [NUM_DIGITS-1:0][3:0]       disp_q, disp_d, buf_q, buf_d;
  logic [NUM_DIGITS-1:0]            dpm_q, dpm_d, bufdp_q, bufdp_d;
  logic                             pend_q, pend_d;
  logic [NUM_DIGITS-1:0]            an_q, an_d;
  logic [3:0]                       bcd_q, bcd_d;
  logic                             dpo_q, dpo_d, tick_q, tick_d;
  logic                             slot_end, frame_end, xfer, lzb;
`ifdef LEADING_ZERO_BLANK_EN
  logic                             zero;
  // zero accumulates "all nibbles from i upward are 0" while walking down from the top digit
  always_comb begin
    lzb  = 1'b0;
    zero = 1'b1;
    for (int i = NUM_DIGITS - 1; i > 0; i--) begin
      zero = zero && (disp_d[i] == 4'h0);
      if (IW'(i) == idx_d) lzb = zero;
    end
  end
`else
  assign lzb = 1'b0;
`endif
  always_comb begin
    slot_end  = cnt_q == LAST_C;
    frame_end = slot_end && (idx_q == LAST_I);
    cnt_d     = slot_end ? '0 : cnt_q + CW'(1);
    idx_d     = slot_end ? ((idx_q == LAST_I) ? '0 : idx_q + IW'(1)) : idx_q;
    phase_d   = (phase_q == BLANK) ? ((cnt_d == BLK_C) ? ON : BLANK) : (slot_end ? BLANK : ON);
    xfer      = bus.load_valid && !pend_q;
    buf_d     = xfer ? bus.load_data : buf_q;
    bufdp_d   = xfer ? bus.load_dp : bufdp_q;
    pend_d    = xfer ? 1'b1 : (frame_end ? 1'b0 : pend_q);
    disp_d    = (frame_end && pend_q) ? buf_q : disp_q;
    dpm_d     = (frame_end && pend_q) ? bufdp_q : dpm_q;
    an_d      = (phase_d == ON) ? ~(NUM_DIGITS'(1) << idx_d) : '1;
    bcd_d     = (phase_d == ON && !lzb) ? disp_d[idx_d] : 4'hF;
    dpo_d     = (phase_d == ON && !lzb) ? ~dpm_d[idx_d] : 1'b1;
    tick_d    = frame_end;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q <= BLANK;
      cnt_q   <= '0;
      idx_q   <= '0;
      disp_q  <= '1;
      dpm_q   <= '0;
      buf_q   <= '0;
      bufdp_q <= '0;
      pend_q  <= 1'b0;
      an_q    <= '1;
      bcd_q   <= 4'hF;
      dpo_q   <= 1'b1;
      tick_q  <= 1'b0;
    end else begin
      phase_q <= phase_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      disp_q  <= disp_d;
      dpm_q   <= dpm_d;
      buf_q   <= buf_d;
      bufdp_q <= bufdp_d;
      pend_q  <= pend_d;
      an_q    <= an_d;
      bcd_q   <= bcd_d;
      dpo_q   <= dpo_d;
      tick_q  <= tick_d;
    end
  end
  assign bus.load_ready = ~pend_q;
  assign bus.an         = an_q;
  assign bus.bcd_out    = bcd_q;
  assign bus.dp_out     = dpo_q;
  assign bus.frame_tick = tick_q;
endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb_seg_scan_ctrl: directed bench for seg_scan_ctrl with NUM_DIGITS=4, CLK_DIV=8, BLANK_CYC=2.
module tb_seg_scan_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  logic [15:0] word_e = 16'hFFFF;
  logic [3:0]  dp_e = 4'h0;
  logic        ready_e = 1'b1;
  seg_scan_if #(.NUM_DIGITS(4)) bus ();
  seg_scan_ctrl #(.NUM_DIGITS(4), .CLK_DIV(8), .BLANK_CYC(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask
  task automatic check_cycle();
    int cnt, idx;
    logic [3:0] an_x, bcd_x;
    logic dp_x;
    logic [15:0] upper;
    cnt   = cyc % 8;
    idx   = (cyc / 8) % 4;
    an_x  = 4'hF;
    bcd_x = 4'hF;
    dp_x  = 1'b1;
    if (cnt >= 2) begin
      an_x[idx] = 1'b0;
      bcd_x = word_e[idx*4 +: 4];
      dp_x  = ~dp_e[idx];
`ifdef LEADING_ZERO_BLANK_EN
      upper = word_e >> (4 * idx);
      if (idx > 0 && upper == 16'h0) begin
        bcd_x = 4'hF;
        dp_x  = 1'b1;
      end
`endif
    end
    chk("an", {12'h0, bus.an}, {12'h0, an_x});
    chk("bcd_out", {12'h0, bus.bcd_out}, {12'h0, bcd_x});
    chk("dp_out", {15'h0, bus.dp_out}, {15'h0, dp_x});
    chk("load_ready", {15'h0, bus.load_ready}, {15'h0, ready_e});
    chk("frame_tick", {15'h0, bus.frame_tick}, {15'h0, (cyc > 0 && cyc % 32 == 0)});
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask
  task automatic run_to(input int n);
    while (cyc < n) begin
      tick();
      check_cycle();
    end
  endtask
  task automatic load(input logic [15:0] d, input logic [3:0] p);
    bus.load_valid = 1'b1;
    bus.load_data  = d;
    bus.load_dp    = p;
    ready_e = 1'b0;
    run_to(cyc + 1);
    bus.load_valid = 1'b0;
  endtask
  task automatic do_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    cyc = 0;
    word_e = 16'hFFFF;
    dp_e = 4'h0;
    ready_e = 1'b1;
    check_cycle();
    rst_n = 1'b1;
  endtask
  initial begin
    bus.load_valid = 1'b0;
    bus.load_data  = 16'h0;
    bus.load_dp    = 4'h0;
    do_reset();
    // idle scan: blank digits, anodes walk, frame_tick every 32 cycles
    run_to(70);
    // single-cycle load mid-frame, applied at boundary edge 96
    load(16'h1234, 4'b0010);
    // hold a second word while pending: ignored until ready rises at 96, captured at edge 97
    bus.load_valid = 1'b1;
    bus.load_data  = 16'h5678;
    bus.load_dp    = 4'b0001;
    run_to(95);
    word_e = 16'h1234;
    dp_e = 4'b0010;
    ready_e = 1'b1;
    run_to(96);
    ready_e = 1'b0;
    run_to(97);
    bus.load_valid = 1'b0;
    run_to(127);
    word_e = 16'h5678;
    dp_e = 4'b0001;
    ready_e = 1'b1;
    run_to(191);
    // transfer on the boundary edge 192: no bypass, shown from 224
    load(16'hCA09, 4'b1000);
    run_to(223);
    word_e = 16'hCA09;
    dp_e = 4'b1000;
    ready_e = 1'b1;
    run_to(260);
    // pending word then async reset at counter 5 of slot 2
    load(16'h7777, 4'b1111);
    run_to(277);
    rst_n = 1'b0;
    #1;
    chk("rst_an", {12'h0, bus.an}, 16'h000F);
    chk("rst_bcd", {12'h0, bus.bcd_out}, 16'h000F);
    chk("rst_ready", {15'h0, bus.load_ready}, 16'h0001);
    chk("rst_dp", {15'h0, bus.dp_out}, 16'h0001);
    do_reset();
    // the discarded word must never appear
    run_to(70);
    load(16'h0040, 4'b0000);
    run_to(95);
    word_e = 16'h0040;
    dp_e = 4'b0000;
    ready_e = 1'b1;
    run_to(100);
    load(16'h0000, 4'b0000);
    run_to(127);
    word_e = 16'h0000;
    ready_e = 1'b1;
    run_to(160);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
